sha_sched_ctrl: RTL and testbench

Sequencer for the SHA-256 message-schedule datapath. It accepts one 512-bit message block and iterates the `sha_datashift` stage. It streams the 64 schedule words W0..W63 to the compression core as 32 word pairs over a valid/ready handshake. It sits between the block-fetch logic, which supplies padded blocks, and the round engine, which consumes two rounds per accepted pair.

---
 rtl/sha_pkg.sv | 23 ++
 rtl/sha_datashift.sv | 19 +
 rtl/sha_sched_ctrl.sv | 85 ++++++++
 tb/tb_sha_sched_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// Shared types and sigma helpers for the SHA-256 message-schedule path.
package sha_pkg;

   typedef logic [31:0]  word_t;
   typedef logic [511:0] block_t;
   typedef logic [63:0]  pair_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } sched_state_t;

   localparam int SHA_ROUNDS = 64;

   function automatic word_t sig0(input word_t x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic word_t sig1(input word_t x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
   endfunction

endpackage

// File: rtl/sha_datashift.sv
// Combinational schedule stage: drops the two oldest window words and
// appends W[t], W[t+1]. Window word i holds W[t-16+i].
module sha_datashift
   import sha_pkg::*;
(
   input  block_t i_win,
   output block_t o_win
);

   word_t w_t0;
   word_t w_t1;

   // W[t+1] needs W[t-1] (word 15), not W[t], so both words evaluate in parallel
   assign w_t0 = sig1(i_win[479:448]) + i_win[319:288] + sig0(i_win[63:32]) + i_win[31:0];
   assign w_t1 = sig1(i_win[511:480]) + i_win[351:320] + sig0(i_win[95:64]) + i_win[63:32];

   assign o_win = {w_t1, w_t0, i_win[511:64]};

endmodule

// File: rtl/sha_sched_ctrl.sv
// SHA-256 message-schedule sequencer: loads a block, streams W0..W(ROUNDS-1)
// as word pairs. Optional zero-bubble block prefetch: SHA_SCHED_PREFETCH_EN.
module sha_sched_ctrl
   import sha_pkg::*;
#(
   parameter  int ROUNDS = SHA_ROUNDS,
   localparam int NPAIRS = ROUNDS / 2,
   localparam int CW     = $clog2(NPAIRS)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          blk_valid,
   output logic          blk_ready,
   input  block_t        blk_data,
   input  logic          abort,
   output logic          w_valid,
   input  logic          w_ready,
   output pair_t         w_pair,
   output logic [CW-1:0] w_idx,
   output logic          w_last,
   output logic          busy
);

   sched_state_t  r_state;
   logic [CW-1:0] r_cnt;
   block_t        r_win;
   block_t        w_next_win;
   logic          w_blk_acc;
   logic          w_pair_acc;

   sha_datashift u_shift (
      .i_win (r_win),
      .o_win (w_next_win)
   );

   assign w_valid    = (r_state == ST_RUN);
   assign busy       = (r_state == ST_RUN);
   assign w_pair     = r_win[63:0];
   assign w_idx      = r_cnt;
   assign w_last     = w_valid && (r_cnt == CW'(NPAIRS - 1));
   assign w_pair_acc = w_valid && w_ready;

   // A block offered alongside abort is refused rather than silently dropped
   always_comb begin
      blk_ready = 1'b0;
      if (r_state == ST_IDLE) begin
         blk_ready = 1'b1;
      end else begin
`ifdef SHA_SCHED_PREFETCH_EN
         blk_ready = w_last && w_ready;
`else
         blk_ready = 1'b0;
`endif
      end
      if (abort) begin
         blk_ready = 1'b0;
      end
   end

   assign w_blk_acc = blk_valid && blk_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_win   <= '0;
      end else if (abort) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else if (w_blk_acc) begin
         r_state <= ST_RUN;
         r_cnt   <= '0;
         r_win   <= blk_data;
      end else if (w_pair_acc) begin
         r_win <= w_next_win;
         if (w_last) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_sha_sched_ctrl.sv
// Self-checking bench for sha_sched_ctrl: scoreboard of expected pairs plus
// per-scenario checks (reset, stall, abort, mid-block reset, back-to-back, ROUNDS=16).
module tb_sha_sched_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

`ifdef SHA_SCHED_PREFETCH_EN
   localparam int EXP_GAP = 0;
`else
   localparam int EXP_GAP = 1;
`endif

   logic         rst, blk_valid, abort, w_ready;
   logic [511:0] blk_data;
   logic         blk_ready, w_valid, w_last, busy;
   logic [63:0]  w_pair;
   logic [4:0]   w_idx;

   logic         v16, a16, r16;
   logic [511:0] d16;
   logic         br16, wv16, wl16, bz16;
   logic [63:0]  wp16;
   logic [2:0]   wi16;

   int checks   = 0;
   int failures = 0;
   logic [69:0] sb_q [$];

   sha_sched_ctrl dut (
      .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(blk_ready),
      .blk_data(blk_data), .abort(abort), .w_valid(w_valid), .w_ready(w_ready),
      .w_pair(w_pair), .w_idx(w_idx), .w_last(w_last), .busy(busy)
   );

   sha_sched_ctrl #(.ROUNDS(16)) dut16 (
      .clk(clk), .rst(rst), .blk_valid(v16), .blk_ready(br16),
      .blk_data(d16), .abort(a16), .w_valid(wv16), .w_ready(r16),
      .w_pair(wp16), .w_idx(wi16), .w_last(wl16), .busy(bz16)
   );

   function automatic logic [31:0] m_s0(input logic [31:0] x);
      return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] m_s1(input logic [31:0] x);
      return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
   endfunction

   function automatic logic [511:0] rand_block();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
      return b;
   endfunction

   // Scoreboard: inputs are driven at negedge, sampled 3 ns later, before the next posedge
   always @(negedge clk) begin
      logic [31:0] mw [64];
      logic [69:0] e;
      #3;
      if (rst || abort) begin
         sb_q.delete();
      end else begin
         if (w_valid && w_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected_pair got idx=%0d pair=%h, no pair expected", w_idx, w_pair);
            end else begin
               e = sb_q.pop_front();
               if ({w_last, w_idx, w_pair} !== e) begin
                  failures++;
                  $display("FAIL sb_pair got last=%b idx=%0d pair=%h exp last=%b idx=%0d pair=%h",
                           w_last, w_idx, w_pair, e[69], e[68:64], e[63:0]);
               end
            end
         end
         if (blk_valid && blk_ready) begin
            for (int i = 0; i < 16; i++) mw[i] = blk_data[32*i +: 32];
            for (int t = 16; t < 64; t++)
               mw[t] = m_s1(mw[t-2]) + mw[t-7] + m_s0(mw[t-15]) + mw[t-16];
            for (int k = 0; k < 32; k++)
               sb_q.push_back({(k == 31), 5'(k), mw[2*k+1], mw[2*k]});
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1; blk_valid = 1'b1; blk_data = rand_block(); abort = 1'b0; w_ready = 1'b0;
      v16 = 1'b0; a16 = 1'b0; r16 = 1'b0; d16 = '0;
      repeat (2) @(negedge clk);
      #4;
      checks++;
      if ({w_valid, busy, w_last, w_idx} !== 8'd0) begin
         failures++;
         $display("FAIL reset_held got valid=%b busy=%b last=%b idx=%0d exp all 0", w_valid, busy, w_last, w_idx);
      end
      @(negedge clk); rst = 1'b0; blk_valid = 1'b0;
      #4;
      checks++;
      if ({blk_ready, w_valid, w_last, busy, w_idx, w_pair} !== {1'b1, 3'b000, 5'd0, 64'd0}) begin
         failures++;
         $display("FAIL reset_vals got rdy=%b valid=%b last=%b busy=%b idx=%0d pair=%h exp 1 0 0 0 0 0",
                  blk_ready, w_valid, w_last, busy, w_idx, w_pair);
      end
   endtask

   task automatic test_abc();
      logic [511:0] b;
      b = '0; b[31:0] = 32'h61626380; b[511:480] = 32'h00000018;
      @(negedge clk); blk_data = b; blk_valid = 1'b1; w_ready = 1'b1;
      #4;
      checks++;
      if (blk_ready !== 1'b1) begin
         failures++; $display("FAIL abc_load_ready got %b exp 1", blk_ready);
      end
      for (int k = 0; k < 32; k++) begin
         @(negedge clk); blk_valid = 1'b0;
         #4;
         checks++;
         if ({w_valid, w_idx, w_last} !== {1'b1, 5'(k), (k == 31)}) begin
            failures++;
            $display("FAIL abc_seq k=%0d got valid=%b idx=%0d last=%b", k, w_valid, w_idx, w_last);
         end
         if (k == 0) begin
            checks++;
            if (w_pair !== 64'h00000000_61626380) begin
               failures++; $display("FAIL abc_pair0 got %h exp 0000000061626380", w_pair);
            end
         end
         if (k == 8) begin
            checks++;
            if (w_pair !== 64'h000F0000_61626380) begin
               failures++; $display("FAIL abc_pair8 got %h exp 000f000061626380", w_pair);
            end
         end
      end
      @(negedge clk);
      #4;
      checks++;
      if ({blk_ready, w_valid, busy} !== 3'b100) begin
         failures++; $display("FAIL abc_done got rdy=%b valid=%b busy=%b exp 1 0 0", blk_ready, w_valid, busy);
      end
   endtask

   task automatic test_backpressure();
      logic        done, stalled;
      logic [63:0] hp;
      logic [4:0]  hi;
      done = 1'b0; stalled = 1'b0; hp = '0; hi = '0;
      @(negedge clk); blk_data = rand_block(); blk_valid = 1'b1; w_ready = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
         @(negedge clk); blk_valid = 1'b0; w_ready = 1'($urandom_range(0, 1));
         #4;
         if (stalled) begin
            checks++;
            if ({w_valid, w_idx, w_pair} !== {1'b1, hi, hp}) begin
               failures++;
               $display("FAIL stall_hold got valid=%b idx=%0d pair=%h exp 1 %0d %h", w_valid, w_idx, w_pair, hi, hp);
            end
         end
         stalled = w_valid && !w_ready;
         hp = w_pair; hi = w_idx;
         if (w_valid && w_ready && w_last) done = 1'b1;
      end
      checks++;
      if (!done) begin
         failures++; $display("FAIL bp_timeout got done=0 exp done=1");
      end
      @(negedge clk); w_ready = 1'b0;
   endtask

   task automatic test_abort();
      logic [511:0] b;
      @(negedge clk); blk_data = rand_block(); blk_valid = 1'b1; w_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); blk_valid = 1'b0; w_ready = 1'b1;
      end
      @(negedge clk); w_ready = 1'b0;
      #4;
      checks++;
      if ({w_valid, w_idx} !== {1'b1, 5'd5}) begin
         failures++; $display("FAIL abort_pre got valid=%b idx=%0d exp 1 5", w_valid, w_idx);
      end
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      #4;
      checks++;
      if ({w_valid, blk_ready, busy, w_idx} !== {3'b010, 5'd0}) begin
         failures++;
         $display("FAIL abort_idle got valid=%b rdy=%b busy=%b idx=%0d exp 0 1 0 0", w_valid, blk_ready, busy, w_idx);
      end
      @(negedge clk); abort = 1'b1; blk_valid = 1'b1; blk_data = rand_block();
      @(negedge clk); abort = 1'b0; blk_valid = 1'b0;
      #4;
      checks++;
      if ({w_valid, busy} !== 2'b00) begin
         failures++; $display("FAIL abort_blocks_load got valid=%b busy=%b exp 0 0", w_valid, busy);
      end
      b = rand_block();
      @(negedge clk); blk_data = b; blk_valid = 1'b1; w_ready = 1'b1;
      @(negedge clk); blk_valid = 1'b0;
      #4;
      checks++;
      if ({w_valid, w_idx, w_pair} !== {1'b1, 5'd0, b[63:0]}) begin
         failures++;
         $display("FAIL abort_restart got valid=%b idx=%0d pair=%h exp 1 0 %h", w_valid, w_idx, w_pair, b[63:0]);
      end
      repeat (32) @(negedge clk);
      #4;
      checks++;
      if ({w_valid, blk_ready} !== 2'b01) begin
         failures++; $display("FAIL abort_restart_done got valid=%b rdy=%b exp 0 1", w_valid, blk_ready);
      end
   endtask

   task automatic test_rst_mid();
      @(negedge clk); blk_data = rand_block(); blk_valid = 1'b1; w_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk); blk_valid = 1'b0;
      end
      @(negedge clk); rst = 1'b1; blk_valid = 1'b1; blk_data = rand_block();
      #4;
      checks++;
      if ({w_valid, w_idx} !== {1'b1, 5'd20}) begin
         failures++; $display("FAIL rst_pre got valid=%b idx=%0d exp 1 20", w_valid, w_idx);
      end
      @(negedge clk); rst = 1'b0; blk_valid = 1'b0;
      #4;
      checks++;
      if ({blk_ready, w_valid, w_last, busy, w_idx, w_pair} !== {1'b1, 3'b000, 5'd0, 64'd0}) begin
         failures++;
         $display("FAIL rst_mid_vals got rdy=%b valid=%b last=%b busy=%b idx=%0d pair=%h exp 1 0 0 0 0 0",
                  blk_ready, w_valid, w_last, busy, w_idx, w_pair);
      end
   endtask

   task automatic test_back_to_back();
      logic [511:0] ba, bb;
      int nacc, gap;
      logic seen_last, got;
      ba = rand_block(); bb = rand_block();
      nacc = 0; gap = 0; seen_last = 1'b0; got = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk);
         w_ready   = 1'b1;
         blk_valid = (nacc < 2);
         blk_data  = (nacc == 0) ? ba : bb;
         #4;
         if (seen_last) begin
            if (!w_valid) gap++;
            else begin
               got = 1'b1;
               checks++;
               if (gap != EXP_GAP || w_idx !== 5'd0 || w_pair !== bb[63:0]) begin
                  failures++;
                  $display("FAIL b2b_gap got gap=%0d idx=%0d pair=%h exp gap=%0d idx=0 pair=%h",
                           gap, w_idx, w_pair, EXP_GAP, bb[63:0]);
               end
            end
         end
         if (!seen_last && w_valid && w_ready && w_last) seen_last = 1'b1;
         if (blk_valid && blk_ready) nacc++;
      end
      checks++;
      if (!got) begin
         failures++; $display("FAIL b2b_timeout got no second block exp second block");
      end
      blk_valid = 1'b0;
      repeat (32) @(negedge clk);
      #4;
      checks++;
      if ({w_valid, blk_ready} !== 2'b01) begin
         failures++; $display("FAIL b2b_done got valid=%b rdy=%b exp 0 1", w_valid, blk_ready);
      end
   endtask

   task automatic test_rounds16();
      logic [511:0] b;
      b = rand_block();
      @(negedge clk); d16 = b; v16 = 1'b1; r16 = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); v16 = 1'b0;
         #4;
         checks++;
         if ({wv16, wi16, wl16, wp16} !== {1'b1, 3'(k), (k == 7), b[64*k +: 64]}) begin
            failures++;
            $display("FAIL r16_pair k=%0d got valid=%b idx=%0d last=%b pair=%h exp pair=%h",
                     k, wv16, wi16, wl16, wp16, b[64*k +: 64]);
         end
      end
      @(negedge clk);
      #4;
      checks++;
      if ({wv16, br16} !== 2'b01) begin
         failures++; $display("FAIL r16_done got valid=%b rdy=%b exp 0 1", wv16, br16);
      end
   endtask

   initial begin
      test_reset();
      test_abc();
      test_backpressure();
      test_abort();
      test_rst_mid();
      test_back_to_back();
      test_rounds16();
      @(negedge clk); #4;
      checks++;
      if (sb_q.size() != 0) begin
         failures++; $display("FAIL sb_drain got %0d pending exp 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
